id_ex_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use bubble insertion.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage_fwd_sel.sv | 29 ++
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU op codes, width defaults and forward-select encoding
package id_ex_stage_pkg;
    localparam int DEF_DW = 32;
    localparam int DEF_RW = 5;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'ha,
        ALU_SLLV = 4'hb,
        ALU_SRLV = 4'hc,
        ALU_SRAV = 4'hd,
        ALU_LUI  = 4'he
    } alu_op_e;
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID inputs, hazard/forwarding tags and EX outputs of the ID/EX stage
interface id_ex_stage_if #(
    parameter int DW = id_ex_stage_pkg::DEF_DW,
    parameter int RW = id_ex_stage_pkg::DEF_RW
);
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_dest;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic [3:0]    id_alu_op;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          mem_reg_write;
    logic [RW-1:0] mem_dest;
    logic [DW-1:0] mem_alu_out;
    logic          wb_reg_write;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic          ld_hazard;
    logic          ex_valid;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [4:0]    alu_shamt;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;

    modport master (
        output stall, flush, id_valid, id_rs, id_rt, id_dest, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_alu_op, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, mem_reg_write, mem_dest, mem_alu_out,
               wb_reg_write, wb_dest, wb_data,
        input  ld_hazard, ex_valid, alu_a, alu_b, alu_op, alu_shamt, ex_store_data,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  stall, flush, id_valid, id_rs, id_rt, id_dest, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_alu_op, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, mem_reg_write, mem_dest, mem_alu_out,
               wb_reg_write, wb_dest, wb_data,
        output ld_hazard, ex_valid, alu_a, alu_b, alu_op, alu_shamt, ex_store_data,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// id_ex_stage_fwd_sel: picks the newest value of one source register (MEM over WB over stored)
module id_ex_stage_fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic [RW-1:0] r,
    input  logic [DW-1:0] data,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_dest,
    input  logic [DW-1:0] mem_alu_out,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_data,
    output logic          wb_hit,
    output logic [DW-1:0] val
);
    logic mem_hit;
    fwd_e sel;

    // $0 is hard-wired, so it never matches a producer
    always_comb begin
        mem_hit = (|r) & mem_reg_write & (mem_dest == r);
        wb_hit  = (|r) & wb_reg_write & (wb_dest == r);
        sel     = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_REG;
        val     = sel == FWD_MEM ? mem_alu_out : sel == FWD_WB ? wb_data : data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input logic clk,
    input logic rst,
    id_ex_stage_if.slave io
);
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        alu_op_e       alu_op;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } ex_t;

    ex_t           ex_q, ex_d, id_ex, hold_ex;
    logic          ld_hazard;
    logic          rs_wb_hit, rt_wb_hit;
    logic [DW-1:0] rs_fwd, rt_fwd;

    id_ex_stage_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
        .r(ex_q.rs), .data(ex_q.rs_data),
        .mem_reg_write(io.mem_reg_write), .mem_dest(io.mem_dest), .mem_alu_out(io.mem_alu_out),
        .wb_reg_write(io.wb_reg_write), .wb_dest(io.wb_dest), .wb_data(io.wb_data),
        .wb_hit(rs_wb_hit), .val(rs_fwd)
    );

    id_ex_stage_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
        .r(ex_q.rt), .data(ex_q.rt_data),
        .mem_reg_write(io.mem_reg_write), .mem_dest(io.mem_dest), .mem_alu_out(io.mem_alu_out),
        .wb_reg_write(io.wb_reg_write), .wb_dest(io.wb_dest), .wb_data(io.wb_data),
        .wb_hit(rt_wb_hit), .val(rt_fwd)
    );

    assign ld_hazard = io.id_valid & ex_q.valid & ex_q.mem_read & (|ex_q.dest)
                     & ((ex_q.dest == io.id_rs) | (ex_q.dest == io.id_rt));

    // next contents: flush beats stall, stall beats the load-use bubble; held operands absorb WB
    always_comb begin
        id_ex = '{
            valid:      io.id_valid,
            rs:         io.id_rs,
            rt:         io.id_rt,
            dest:       io.id_dest,
            rs_data:    io.id_rs_data,
            rt_data:    io.id_rt_data,
            imm:        io.id_imm,
            shamt:      io.id_shamt,
            alu_op:     alu_op_e'(io.id_alu_op),
            alu_src:    io.id_alu_src,
            reg_write:  io.id_valid & io.id_reg_write,
            mem_read:   io.id_valid & io.id_mem_read,
            mem_write:  io.id_valid & io.id_mem_write,
            mem_to_reg: io.id_valid & io.id_mem_to_reg
        };
        hold_ex = ex_q;
        hold_ex.rs_data = rs_wb_hit ? io.wb_data : ex_q.rs_data;
        hold_ex.rt_data = rt_wb_hit ? io.wb_data : ex_q.rt_data;
        ex_d = io.flush ? ex_t'(0) : io.stall ? hold_ex : ld_hazard ? ex_t'(0) : id_ex;
    end

    // pipeline register; reset clears every field, including alu_op (ADD)
    always_ff @(posedge clk) begin
        ex_q <= rst ? ex_t'(0) : ex_d;
    end

    assign io.ld_hazard     = ld_hazard;
    assign io.ex_valid      = ex_q.valid;
    assign io.alu_a         = rs_fwd;
    assign io.alu_b         = ex_q.alu_src ? ex_q.imm : rt_fwd;
    assign io.alu_op        = ex_q.alu_op;
    assign io.alu_shamt     = ex_q.shamt;
    assign io.ex_store_data = rt_fwd;
    assign io.ex_dest       = ex_q.dest;
    assign io.ex_reg_write  = ex_q.reg_write;
    assign io.ex_mem_read   = ex_q.mem_read;
    assign io.ex_mem_write  = ex_q.mem_write;
    assign io.ex_mem_to_reg = ex_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors against a behavioural ID/EX model plus literal spot checks
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_stage_if io ();
    id_ex_stage dut (.clk(clk), .rst(rst), .io(io.slave));

    logic        m_v = 0, m_src = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_m2r = 0;
    logic [4:0]  m_rs = 0, m_rt = 0, m_dest = 0, m_sh = 0;
    logic [3:0]  m_op = 0;
    logic [31:0] m_rsv = 0, m_rtv = 0, m_imm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_haz();
        return io.id_valid && m_v && m_mr && m_dest != 0 && (m_dest == io.id_rs || m_dest == io.id_rt);
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (io.mem_reg_write && io.mem_dest == r) return io.mem_alu_out;
        if (io.wb_reg_write && io.wb_dest == r) return io.wb_data;
        return v;
    endfunction

    // reference model of what sits in the EX slot
    always @(posedge clk) begin
        if (rst || io.flush || (!io.stall && m_haz())) begin
            {m_v, m_src, m_rw, m_mr, m_mw, m_m2r} <= '0;
            {m_rs, m_rt, m_dest, m_sh, m_op} <= '0;
            {m_rsv, m_rtv, m_imm} <= '0;
        end else if (io.stall) begin
            if (m_rs != 0 && io.wb_reg_write && io.wb_dest == m_rs) m_rsv <= io.wb_data;
            if (m_rt != 0 && io.wb_reg_write && io.wb_dest == m_rt) m_rtv <= io.wb_data;
        end else begin
            m_v <= io.id_valid;
            m_src <= io.id_alu_src;
            m_rw <= io.id_valid & io.id_reg_write;
            m_mr <= io.id_valid & io.id_mem_read;
            m_mw <= io.id_valid & io.id_mem_write;
            m_m2r <= io.id_valid & io.id_mem_to_reg;
            m_rs <= io.id_rs;
            m_rt <= io.id_rt;
            m_dest <= io.id_dest;
            m_sh <= io.id_shamt;
            m_op <= io.id_alu_op;
            m_rsv <= io.id_rs_data;
            m_rtv <= io.id_rt_data;
            m_imm <= io.id_imm;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("ld_hazard", io.ld_hazard, m_haz());
            chk("ex_valid", io.ex_valid, m_v);
            chk("alu_a", io.alu_a, m_fwd(m_rs, m_rsv));
            chk("alu_b", io.alu_b, m_src ? m_imm : m_fwd(m_rt, m_rtv));
            chk("store_data", io.ex_store_data, m_fwd(m_rt, m_rtv));
            chk("alu_op", io.alu_op, m_op);
            chk("alu_shamt", io.alu_shamt, m_sh);
            chk("ex_dest", io.ex_dest, m_dest);
            chk("ctrl", {io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.ex_mem_to_reg},
                {m_rw, m_mr, m_mw, m_m2r});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        io.stall = 0; io.flush = 0; io.id_valid = 0;
        io.id_rs = 0; io.id_rt = 0; io.id_dest = 0;
        io.id_rs_data = 0; io.id_rt_data = 0; io.id_imm = 0; io.id_shamt = 0;
        io.id_alu_op = 0; io.id_alu_src = 0;
        io.id_reg_write = 0; io.id_mem_read = 0; io.id_mem_write = 0; io.id_mem_to_reg = 0;
        io.mem_reg_write = 0; io.mem_dest = 0; io.mem_alu_out = 0;
        io.wb_reg_write = 0; io.wb_dest = 0; io.wb_data = 0;
    endtask

    // ctl = {reg_write, mem_read, mem_write, mem_to_reg}
    task automatic idi(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic src, input logic [3:0] ctl, input logic [3:0] op);
        io.id_valid = 1; io.id_rs = rs; io.id_rt = rt; io.id_dest = dest;
        io.id_rs_data = rsd; io.id_rt_data = rtd; io.id_imm = imm;
        io.id_shamt = rs ^ dest; io.id_alu_src = src; io.id_alu_op = op;
        {io.id_reg_write, io.id_mem_read, io.id_mem_write, io.id_mem_to_reg} = ctl;
    endtask

    initial begin
        quiet();
        rst = 1;
        cyc();
        cyc();
        armed = 1;
        settle();
        chk("rst_valid", io.ex_valid, 0);
        chk("rst_reg_write", io.ex_reg_write, 0);
        chk("rst_mem_read", io.ex_mem_read, 0);
        chk("rst_alu_a", io.alu_a, 0);
        chk("rst_alu_b", io.alu_b, 0);
        chk("rst_alu_op", io.alu_op, ALU_ADD);
        rst = 0;

        idi(3, 1, 6, 32'h5, 32'h22, 32'h0, 0, 4'b1000, ALU_ADD);
        io.mem_reg_write = 1; io.mem_dest = 3; io.mem_alu_out = 32'h10;
        cyc();
        settle();
        chk("mem_fwd_a", io.alu_a, 32'h10);
        chk("mem_fwd_b", io.alu_b, 32'h22);
        io.wb_reg_write = 1; io.wb_dest = 3; io.wb_data = 32'h7;
        settle();
        chk("mem_over_wb", io.alu_a, 32'h10);
        io.mem_reg_write = 0;
        settle();
        chk("wb_fwd", io.alu_a, 32'h7);
        io.wb_reg_write = 0;
        settle();
        chk("reg_val", io.alu_a, 32'h5);

        idi(0, 0, 2, 32'h0, 32'h0, 32'h0, 0, 4'b1000, ALU_OR);
        io.mem_reg_write = 1; io.mem_dest = 0; io.mem_alu_out = 32'hFFFF;
        io.wb_reg_write = 1; io.wb_dest = 0; io.wb_data = 32'h1234;
        cyc();
        settle();
        chk("zero_guard_a", io.alu_a, 0);
        chk("zero_guard_st", io.ex_store_data, 0);

        quiet();
        idi(2, 0, 4, 32'h100, 32'h0, 32'h8, 1, 4'b1101, ALU_ADD);
        cyc();
        idi(1, 4, 7, 32'h1, 32'hDEAD, 32'h0, 0, 4'b1000, ALU_ADD);
        settle();
        chk("lu_hazard", io.ld_hazard, 1);
        chk("lu_alu_b_addr", io.alu_b, 32'h8);
        cyc();
        io.mem_reg_write = 1; io.mem_dest = 4; io.mem_alu_out = 32'h108;
        settle();
        chk("lu_bubble", io.ex_valid, 0);
        chk("lu_hazard_gone", io.ld_hazard, 0);
        cyc();
        io.mem_reg_write = 0;
        io.wb_reg_write = 1; io.wb_dest = 4; io.wb_data = 32'h55;
        settle();
        chk("lu_enter", io.ex_valid, 1);
        chk("lu_wb_b", io.alu_b, 32'h55);
        chk("lu_a", io.alu_a, 32'h1);
        chk("lu_dest", io.ex_dest, 7);

        quiet();
        idi(6, 5, 8, 32'h6, 32'h1111, 32'h0, 0, 4'b1000, ALU_SUB);
        cyc();
        io.stall = 1;
        idi(9, 9, 9, 32'h9, 32'h9, 32'h9, 1, 4'b1000, ALU_XOR);
        io.wb_reg_write = 1; io.wb_dest = 5; io.wb_data = 32'hABCD;
        cyc();
        io.wb_reg_write = 0;
        cyc();
        cyc();
        io.stall = 0;
        settle();
        chk("refresh_b", io.alu_b, 32'hABCD);
        chk("refresh_st", io.ex_store_data, 32'hABCD);
        chk("refresh_op", io.alu_op, ALU_SUB);
        chk("refresh_dest", io.ex_dest, 8);

        quiet();
        idi(1, 2, 3, 32'h11, 32'h22, 32'h0, 0, 4'b1010, ALU_ADD);
        cyc();
        settle();
        chk("pre_flush_mw", io.ex_mem_write, 1);
        io.flush = 1; io.stall = 1;
        cyc();
        quiet();
        settle();
        chk("fs_valid", io.ex_valid, 0);
        chk("fs_reg_write", io.ex_reg_write, 0);
        chk("fs_mem_write", io.ex_mem_write, 0);

        idi(3, 4, 5, 32'h33, 32'h44, 32'h0, 0, 4'b1000, ALU_AND);
        cyc();
        io.stall = 1;
        rst = 1;
        cyc();
        rst = 0;
        settle();
        chk("rst_hold_valid", io.ex_valid, 0);
        chk("rst_hold_a", io.alu_a, 0);
        quiet();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
